// File: rtl/goldschmidt_divseq_pkg.sv
// Shared state encoding and fixed-point helpers for the sequenced Goldschmidt divider.
package goldschmidt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCL_D,
    SCL_N,
    IT_D,
    IT_N,
    REM,
    FIX,
    DONE
  } state_t;

  localparam int MAXW = 128;

  // Internal N/D/K width: integer bits for values up to 4 plus guard fraction bits.
  function automatic int calc_iw(input int width, input int guard);
    return width + guard + 2;
  endfunction

  function automatic int calc_cw(input int iter);
    return $clog2(iter + 1);
  endfunction

  // 2 - x for x in (0,2) with fbits fraction bits: two's complement kept to fbits+1 bits.
  function automatic logic [MAXW-1:0] two_minus(input logic [MAXW-1:0] x, input int fbits);
    logic [MAXW-1:0] mask;
    mask = (MAXW'(1) << (fbits + 1)) - MAXW'(1);
    return (~x + MAXW'(1)) & mask;
  endfunction

endpackage

// File: rtl/goldschmidt_divseq_gs_mul.sv
// Shared unsigned multiplier; full_i returns the whole product, otherwise the
// product is truncated by SH fraction bits to stay in the operands' format.
module gs_mul #(
  parameter int W  = 63,
  parameter int SH = 60
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           full_i,
  output logic [2*W-1:0] p_o
);
  logic [2*W-1:0] prod;

  assign prod = (2*W)'(a_i) * (2*W)'(b_i);
  assign p_o  = full_i ? prod : (prod >> SH);

endmodule

// File: rtl/goldschmidt_divseq.sv
// Self-sequencing Goldschmidt mantissa divider: scale, iterate, back-multiply,
// then one +/-1 ulp correction giving an exactly truncated quotient and remainder.
module goldschmidt_divseq
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH   = 53,
  parameter int IA_BITS = 12,
  parameter int ITER    = 3,
  parameter int GUARD   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   n,
  input  logic [WIDTH-1:0]   d,
  input  logic [IA_BITS-1:0] ia,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     q,
  output logic [WIDTH-1:0]   rem,
  output logic               rem_zero,
  output logic               dz
);
  localparam int IW     = calc_iw(WIDTH, GUARD);
  localparam int CW     = calc_cw(ITER);
  localparam int F      = WIDTH - 1 + GUARD;
  localparam int RW     = 2 * WIDTH + 2;
  localparam int IA_PAD = F - (IA_BITS - 1);

  if ((IA_BITS - 2) * (2 ** ITER) < WIDTH + 2) begin : gIterCheck
    $error("goldschmidt_divseq: ITER too small for IA_BITS and WIDTH");
  end
  if (GUARD < 1 || IA_PAD < 1 || IW > MAXW) begin : gShapeCheck
    $error("goldschmidt_divseq: unsupported WIDTH/GUARD/IA_BITS combination");
  end

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     nIn_q, dIn_q, rem_q, fixRem;
  logic [IA_BITS-1:0]   iaIn_q;
  logic [IW-1:0]        accN_q, accD_q, k_q, kNext;
  logic [IW-1:0]        nExt, dExt, iaExt, mulA, mulB, mulTrunc;
  logic [CW-1:0]        cnt_q, cntNext;
  logic [WIDTH:0]       qTmp_q, qTmpNext, quot_q, fixQ;
  logic signed [RW-1:0] r_q, rNext, dWide, fixRemWide;
  logic                 remZero_q, dz_q, mulFull;
  logic [2*IW-1:0]      mulP;
  logic                 unusedMulBits;

  // Operands aligned to the internal Q.F format before scaling.
  assign nExt  = {2'b00, nIn_q, {GUARD{1'b0}}};
  assign dExt  = {2'b00, dIn_q, {GUARD{1'b0}}};
  assign iaExt = {2'b00, iaIn_q, {IA_PAD{1'b0}}};

  assign kNext         = IW'(two_minus(MAXW'(accD_q), F));
  assign cntNext       = cnt_q + CW'(1);
  assign qTmpNext      = accN_q[GUARD-1 +: WIDTH+1];
  assign mulTrunc      = mulP[IW-1:0];
  assign unusedMulBits = ^mulP;
  assign dWide         = RW'(dIn_q);
  assign rNext         = $signed({2'b00, nIn_q, {WIDTH{1'b0}}}) - $signed({1'b0, mulP[2*WIDTH:0]});

  gs_mul #(.W(IW), .SH(F)) uMul (
    .a_i   (mulA),
    .b_i   (mulB),
    .full_i(mulFull),
    .p_o   (mulP)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mulA      = '0;
    mulB      = '0;
    mulFull   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = d[WIDTH-1] ? SCL_D : DONE;
      end
      SCL_D: begin
        mulA    = dExt;
        mulB    = iaExt;
        state_d = SCL_N;
      end
      SCL_N: begin
        mulA    = nExt;
        mulB    = iaExt;
        state_d = IT_D;
      end
      IT_D: begin
        mulA    = accD_q;
        mulB    = kNext;
        state_d = IT_N;
      end
      IT_N: begin
        mulA    = accN_q;
        mulB    = k_q;
        state_d = (cntNext == CW'(ITER)) ? REM : IT_D;
      end
      REM: begin
        mulA    = IW'(qTmpNext);
        mulB    = IW'(dIn_q);
        mulFull = 1'b1;
        state_d = FIX;
      end
      FIX: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The estimate is within one ulp, so a single signed test of r picks the fix.
  always_comb begin
    fixQ       = qTmp_q;
    fixRemWide = r_q;
    if (r_q[RW-1]) begin
      fixQ       = qTmp_q - (WIDTH+1)'(1);
      fixRemWide = r_q + dWide;
    end else if (r_q >= dWide) begin
      fixQ       = qTmp_q + (WIDTH+1)'(1);
      fixRemWide = r_q - dWide;
    end
    fixRem = fixRemWide[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nIn_q     <= '0;
      dIn_q     <= '0;
      iaIn_q    <= '0;
      accN_q    <= '0;
      accD_q    <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      qTmp_q    <= '0;
      r_q       <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      remZero_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            nIn_q  <= n;
            dIn_q  <= d;
            iaIn_q <= ia;
            cnt_q  <= '0;
            if (!d[WIDTH-1]) begin
              quot_q    <= '1;
              rem_q     <= '0;
              remZero_q <= 1'b0;
              dz_q      <= 1'b1;
            end else begin
              dz_q <= 1'b0;
            end
          end
        end
        SCL_D: accD_q <= mulTrunc;
        SCL_N: accN_q <= mulTrunc;
        IT_D: begin
          k_q    <= kNext;
          accD_q <= mulTrunc;
        end
        IT_N: begin
          accN_q <= mulTrunc;
          cnt_q  <= cntNext;
        end
        REM: begin
          qTmp_q <= qTmpNext;
          r_q    <= rNext;
        end
        FIX: begin
          quot_q    <= fixQ;
          rem_q     <= fixRem;
          remZero_q <= (fixRem == '0);
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!reset && state_q == DONE && !dz_q) begin
      assert (rem_q < dIn_q);
    end
  end

  assign q        = quot_q;
  assign rem      = rem_q;
  assign rem_zero = remZero_q;
  assign dz       = dz_q;

endmodule

// File: tb/tb_goldschmidt_divseq.sv
// Directed and randomised checks of the Goldschmidt divider at the default
// 53-bit width and at a 24-bit configuration compared against integer division.
module tb_goldschmidt_divseq;
  localparam int SW = 24;

  localparam logic [52:0] ONE      = 53'h10_0000_0000_0000;
  localparam logic [52:0] ONE_HALF = 53'h18_0000_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        inValid, inReady, outValid, outReady, remZero, dzOut;
  logic [52:0] nIn, dIn, remOut;
  logic [11:0] iaIn;
  logic [53:0] qOut;

  logic          sInValid, sInReady, sOutValid, sOutReady, sRemZero, sDz;
  logic [SW-1:0] sN, sD, sRem;
  logic [7:0]    sIa;
  logic [SW:0]   sQ;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  goldschmidt_divseq dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .n(nIn), .d(dIn), .ia(iaIn), .out_valid(outValid), .out_ready(outReady),
    .q(qOut), .rem(remOut), .rem_zero(remZero), .dz(dzOut)
  );

  goldschmidt_divseq #(.WIDTH(SW), .IA_BITS(8), .ITER(3), .GUARD(8)) dutS (
    .clk(clk), .reset(reset), .in_valid(sInValid), .in_ready(sInReady),
    .n(sN), .d(sD), .ia(sIa), .out_valid(sOutValid), .out_ready(sOutReady),
    .q(sQ), .rem(sRem), .rem_zero(sRemZero), .dz(sDz)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set to the wide instance and return at the negedge after acceptance.
  task automatic applyStimulus(input logic [52:0] nv, input logic [52:0] dv, input logic [11:0] iav);
    @(negedge clk);
    checkOutput("accept_ready", inReady, 1);
    nIn = nv;
    dIn = dv;
    iaIn = iav;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    nIn = '0;
    dIn = '0;
    iaIn = '0;
  endtask

  task automatic waitResult(output int edges);
    edges = 1;
    while (!outValid && edges < 60) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic retireResult();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [52:0] nv, input logic [52:0] dv,
                           input logic [11:0] iav, input logic [53:0] expQ,
                           input logic [52:0] expRem, input logic expRz);
    int edges;
    applyStimulus(nv, dv, iav);
    waitResult(edges);
    checkOutput({tag, "_latency"}, edges, 11);
    checkOutput({tag, "_q"}, qOut, expQ);
    checkOutput({tag, "_rem"}, remOut, expRem);
    checkOutput({tag, "_rem_zero"}, remZero, expRz);
    checkOutput({tag, "_dz"}, dzOut, 0);
    checkOutput({tag, "_busy_ready"}, inReady, 0);
    retireResult();
  endtask

  // Narrow instance: expected quotient and remainder come from exact integer division.
  task automatic runSmall(input logic [SW-1:0] nv, input logic [SW-1:0] dv, input logic [7:0] iav);
    int edges;
    longint unsigned nl, dl, qe, re;
    @(negedge clk);
    checkOutput("s_accept_ready", sInReady, 1);
    sN = nv;
    sD = dv;
    sIa = iav;
    sInValid = 1'b1;
    @(negedge clk);
    sInValid = 1'b0;
    edges = 1;
    while (!sOutValid && edges < 60) begin
      @(negedge clk);
      edges++;
    end
    nl = longint'(nv);
    dl = longint'(dv);
    qe = (nl << SW) / dl;
    re = (nl << SW) % dl;
    checkOutput("s_latency", edges, 11);
    checkOutput("s_q", sQ, qe);
    checkOutput("s_rem", sRem, re);
    checkOutput("s_rem_zero", sRemZero, (re == 0));
    checkOutput("s_dz", sDz, 0);
    sOutReady = 1'b1;
    @(negedge clk);
    sOutReady = 1'b0;
  endtask

  function automatic logic [7:0] smallIa(input logic [SW-1:0] dv, input int delta);
    longint base;
    base = (longint'(1) << 30) / longint'(dv);
    return 8'(base + delta);
  endfunction

  initial begin
    int edges;
    logic [SW-1:0] rn, rd;
    inValid = 1'b0; outReady = 1'b0; nIn = '0; dIn = '0; iaIn = '0;
    sInValid = 1'b0; sOutReady = 1'b0; sN = '0; sD = '0; sIa = '0;

    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", inReady, 1);
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_q", qOut, 0);
    checkOutput("reset_rem", remOut, 0);
    checkOutput("reset_rem_zero", remZero, 0);
    checkOutput("reset_dz", dzOut, 0);
    reset = 1'b0;

    runVector("one_by_one", ONE, ONE, 12'h800, 54'h20_0000_0000_0000, 53'h0, 1'b1);
    runVector("onehalf_by_one", ONE_HALF, ONE, 12'h800, 54'h30_0000_0000_0000, 53'h0, 1'b1);
    runVector("one_by_onehalf", ONE, ONE_HALF, 12'h555, 54'h15_5555_5555_5555,
              53'h08_0000_0000_0000, 1'b0);

    // Divide by zero; stray in_valid while holding must be ignored.
    applyStimulus(ONE, 53'h0, 12'h000);
    waitResult(edges);
    checkOutput("dz_latency", edges, 1);
    checkOutput("dz_flag", dzOut, 1);
    checkOutput("dz_q", qOut, {54{1'b1}});
    checkOutput("dz_rem", remOut, 0);
    checkOutput("dz_rem_zero", remZero, 0);
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      nIn = ONE_HALF;
      dIn = ONE;
      iaIn = 12'h800;
      @(negedge clk);
      checkOutput("dz_hold_valid", outValid, 1);
      checkOutput("dz_hold_ready", inReady, 0);
      checkOutput("dz_hold_q", qOut, {54{1'b1}});
      checkOutput("dz_hold_flag", dzOut, 1);
    end
    inValid = 1'b0;
    retireResult();
    checkOutput("dz_retire_ready", inReady, 1);
    checkOutput("dz_retire_valid", outValid, 0);

    // Abort mid-iteration: after four edges the sequencer is in IT_N.
    applyStimulus(ONE, ONE, 12'h800);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_in_ready", inReady, 1);
    checkOutput("abort_out_valid", outValid, 0);
    checkOutput("abort_q", qOut, 0);
    checkOutput("abort_dz", dzOut, 0);
    repeat (15) @(negedge clk);
    checkOutput("abort_no_output", outValid, 0);
    runVector("after_abort", ONE, ONE, 12'h800, 54'h20_0000_0000_0000, 53'h0, 1'b1);

    // Narrow instance corners, then random operands with +/-1 LSB reciprocal error.
    runSmall(24'h80_0000, 24'h80_0000, smallIa(24'h80_0000, 1));
    runSmall(24'hFF_FFFF, 24'h80_0000, smallIa(24'h80_0000, -1));
    runSmall(24'h80_0000, 24'hFF_FFFF, smallIa(24'hFF_FFFF, 1));
    runSmall(24'hFF_FFFF, 24'hFF_FFFF, smallIa(24'hFF_FFFF, -1));
    runSmall(24'hC0_0000, 24'hA0_0000, smallIa(24'hA0_0000, 0));
    for (int i = 0; i < 300; i++) begin
      rn = SW'($urandom_range(32'h00FF_FFFF, 32'h0080_0000));
      rd = SW'($urandom_range(32'h00FF_FFFF, 32'h0080_0000));
      runSmall(rn, rd, smallIa(rd, int'($urandom_range(2)) - 1));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
